// File: rtl/xcorr_peak_align.sv
// Preamble peak detector and frame aligner: delays the I/Q stream and marks the SOP once a
// correlation peak is confirmed; the detect flag is held for a programmable time with lockout.
module xcorr_peak_align #(
  parameter int DW  = 12,
  parameter int MW  = 24,
  parameter int AW  = 14,
  parameter int WIN = 16,
  parameter int HW  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ival,
  input  logic signed [DW-1:0] data_i,
  input  logic signed [DW-1:0] data_q,
  input  logic                 mval,
  input  logic [MW-1:0]        metric,
  input  logic [MW-1:0]        thr_lvl,
  input  logic [AW-1:0]        addr_shft,
  input  logic [HW-1:0]        hold_len,
  output logic signed [DW-1:0] odata_i,
  output logic signed [DW-1:0] odata_q,
  output logic                 oval,
  output logic                 osop,
  output logic                 corr_dtct,
  output logic [MW-1:0]        peak_val
);

  localparam int CW = $clog2(WIN);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 2);

  typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

  logic [2*DW-1:0] mem [2**AW];
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   rd_addr;
  logic [2*DW-1:0] rd_word;
  logic [DW-1:0]   odi_q, odq_q;
  logic            oval_q;

  state_t          state_q, state_d;
  logic [MW-1:0]   peak_q, peak_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            dtct_q, dtct_d;
  logic [MW-1:0]   pval_q, pval_d;
  logic            pend_q, pend_d;
  logic            osop_q, osop_d;

  // Zero shift would read the slot being written this cycle, so bypass the RAM.
  assign rd_addr = wp_q - addr_shft;
  assign rd_word = (addr_shft == '0) ? {data_i, data_q} : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (ival) mem[wp_q] <= {data_i, data_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q   <= '0;
      odi_q  <= '0;
      odq_q  <= '0;
      oval_q <= 1'b0;
    end else begin
      oval_q <= ival;
      if (ival) begin
        wp_q           <= wp_q + 1'b1;
        {odi_q, odq_q} <= rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      peak_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      dtct_q  <= 1'b0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      osop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dtct_q  <= dtct_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      osop_q  <= osop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dtct_d  = dtct_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    osop_d  = 1'b0;
    // The mark rides on the next output sample; a decision this edge waits for the following one.
    if (ival && pend_q) begin
      osop_d = 1'b1;
      pend_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (mval && (metric > thr_lvl)) begin
          state_d = SEARCH;
          peak_d  = metric;
          cnt_d   = '0;
        end
      end
      SEARCH: begin
        if (mval) begin
          if (metric > peak_q) begin
            peak_d = metric;
            cnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
            pval_d  = peak_q;
            dtct_d  = 1'b1;
            pend_d  = 1'b1;
            hold_d  = (hold_len == '0) ? HW'(1) : hold_len;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (hold_q == HW'(1)) begin
          state_d = IDLE;
          dtct_d  = 1'b0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign odata_i   = odi_q;
  assign odata_q   = odq_q;
  assign oval      = oval_q;
  assign osop      = osop_q;
  assign corr_dtct = dtct_q;
  assign peak_val  = pval_q;

endmodule

// File: tb/tb_xcorr_peak_align.sv
// Directed bench for xcorr_peak_align: delay line, peak search, hold/lockout, SOP mark and async reset.
module tb_xcorr_peak_align;
  localparam int DW = 12, MW = 24, AW = 14, WIN = 16, HW = 13;

  logic clk = 1'b0;
  logic rst, ival, mval;
  logic [DW-1:0] data_i, data_q;
  logic [MW-1:0] metric, thr_lvl;
  logic [AW-1:0] addr_shft;
  logic [HW-1:0] hold_len;
  logic [DW-1:0] odata_i, odata_q;
  logic oval, osop, corr_dtct;
  logic [MW-1:0] peak_val;

  int tests = 0;
  int fails = 0;
  int sidx  = 0;

  xcorr_peak_align #(.DW(DW), .MW(MW), .AW(AW), .WIN(WIN), .HW(HW)) dut (
    .clk(clk), .rst(rst), .ival(ival), .data_i(data_i), .data_q(data_q),
    .mval(mval), .metric(metric), .thr_lvl(thr_lvl), .addr_shft(addr_shft),
    .hold_len(hold_len), .odata_i(odata_i), .odata_q(odata_q), .oval(oval),
    .osop(osop), .corr_dtct(corr_dtct), .peak_val(peak_val)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dvi(input int k);
    logic [31:0] t;
    t = k;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] dvq(input int k);
    return dvi(k) ^ 12'h5A5;
  endfunction

  task automatic cyc(input logic iv, input logic mv, input int m);
    ival   = iv;
    mval   = mv;
    metric = MW'(m);
    data_i = dvi(sidx);
    data_q = dvq(sidx);
    @(posedge clk);
    #1;
    if (iv) sidx++;
  endtask

  task automatic apply_reset;
    ival = 1'b0; mval = 1'b0; metric = '0; data_i = '0; data_q = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    sidx = 0;
  endtask

  task automatic release_reset;
    ival = 1'b0; mval = 1'b0; metric = '0;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    sidx = 0;
  endtask

  task automatic test_reset;
    ival = 1'b1; mval = 1'b1; metric = 24'd5000; thr_lvl = 24'd400;
    addr_shft = '0; hold_len = 13'd64;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({oval, osop, corr_dtct} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b exp 000", {oval, osop, corr_dtct});
    end
    tests++;
    if (peak_val !== '0 || odata_i !== '0 || odata_q !== '0) begin
      fails++; $display("FAIL reset_data got pk=%0d i=%h q=%h exp 0", peak_val, odata_i, odata_q);
    end
    apply_reset;
  endtask

  task automatic test_no_detect_delay;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = 14'd5; hold_len = 13'd64;
    for (int n = 0; n < 120; n++) begin
      cyc(1'b1, 1'b1, (n * 7) % 301);
      tests++;
      if (osop !== 1'b0 || corr_dtct !== 1'b0 || oval !== 1'b1) begin
        fails++; $display("FAIL t1_flags n=%0d osop=%b dtct=%b oval=%b exp 0 0 1", n, osop, corr_dtct, oval);
      end
      if (n >= 5) begin
        tests++;
        if (odata_i !== dvi(n - 5) || odata_q !== dvq(n - 5)) begin
          fails++; $display("FAIL t1_odata n=%0d got %h/%h exp %h/%h", n, odata_i, odata_q, dvi(n - 5), dvq(n - 5));
        end
      end
    end
  endtask

  task automatic test_single_peak;
    int nsop;
    nsop = 0;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = '0; hold_len = 13'd64;
    for (int n = 0; n <= 200; n++) begin
      cyc(1'b1, 1'b1, (n == 100) ? 500 : 0);
      if (osop) nsop++;
      tests++;
      if (corr_dtct !== (n >= 115 && n <= 178)) begin
        fails++; $display("FAIL t2_dtct n=%0d got %b", n, corr_dtct);
      end
      tests++;
      if (osop !== (n == 116)) begin
        fails++; $display("FAIL t2_osop n=%0d got %b", n, osop);
      end
      tests++;
      if (odata_i !== dvi(n) || odata_q !== dvq(n)) begin
        fails++; $display("FAIL t2_passthru n=%0d got %h/%h exp %h/%h", n, odata_i, odata_q, dvi(n), dvq(n));
      end
      if (n == 114 || n == 115) begin
        tests++;
        if (peak_val !== ((n == 115) ? 24'd500 : 24'd0)) begin
          fails++; $display("FAIL t2_peak n=%0d got %0d", n, peak_val);
        end
      end
    end
    tests++;
    if (nsop != 1) begin
      fails++; $display("FAIL t2_sop_count got %0d exp 1", nsop);
    end
  endtask

  task automatic test_multi_peak;
    int m;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = '0; hold_len = 13'd64;
    for (int n = 0; n <= 130; n++) begin
      case (n)
        100: m = 450;
        101: m = 600;
        102: m = 550;
        110: m = 700;
        default: m = 0;
      endcase
      cyc(1'b1, 1'b1, m);
      tests++;
      if (corr_dtct !== (n >= 125)) begin
        fails++; $display("FAIL t3_dtct n=%0d got %b", n, corr_dtct);
      end
      tests++;
      if (osop !== (n == 126)) begin
        fails++; $display("FAIL t3_osop n=%0d got %b", n, osop);
      end
      if (n == 125) begin
        tests++;
        if (peak_val !== 24'd700) begin
          fails++; $display("FAIL t3_peak got %0d exp 700", peak_val);
        end
      end
    end
  endtask

  task automatic test_lockout;
    int m;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = '0; hold_len = 13'd20;
    for (int n = 0; n <= 180; n++) begin
      case (n)
        100: m = 500;
        125: m = 900;
        135: m = 700;
        155: m = 900;
        default: m = 0;
      endcase
      if (n >= 160) hold_len = '0;
      cyc(1'b1, 1'b1, m);
      tests++;
      if (corr_dtct !== ((n >= 115 && n <= 134) || n == 170)) begin
        fails++; $display("FAIL t4_dtct n=%0d got %b", n, corr_dtct);
      end
      tests++;
      if (osop !== (n == 116 || n == 171)) begin
        fails++; $display("FAIL t4_osop n=%0d got %b", n, osop);
      end
      if (n == 134 || n == 169) begin
        tests++;
        if (peak_val !== 24'd500) begin
          fails++; $display("FAIL t4_peak_hold n=%0d got %0d exp 500", n, peak_val);
        end
      end
      if (n == 170) begin
        tests++;
        if (peak_val !== 24'd900) begin
          fails++; $display("FAIL t4_peak_new got %0d exp 900", peak_val);
        end
      end
    end
  endtask

  task automatic test_gapped;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = 14'd3; hold_len = 13'd64;
    for (int n = 0; n <= 150; n++) begin
      cyc(1'b1, 1'b1, (n == 100) ? 500 : 0);
      tests++;
      if (oval !== 1'b1 || osop !== (n == 116) || corr_dtct !== (n >= 115 && n <= 146)) begin
        fails++; $display("FAIL t5_valid n=%0d oval=%b osop=%b dtct=%b", n, oval, osop, corr_dtct);
      end
      if (n >= 3) begin
        tests++;
        if (odata_i !== dvi(n - 3) || odata_q !== dvq(n - 3)) begin
          fails++; $display("FAIL t5_odata n=%0d got %h/%h exp %h/%h", n, odata_i, odata_q, dvi(n - 3), dvq(n - 3));
        end
      end
      cyc(1'b0, 1'b0, 0);
      tests++;
      if (oval !== 1'b0 || osop !== 1'b0 || corr_dtct !== (n >= 115 && n <= 146)) begin
        fails++; $display("FAIL t5_gap n=%0d oval=%b osop=%b dtct=%b", n, oval, osop, corr_dtct);
      end
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    thr_lvl = 24'd400; addr_shft = '0; hold_len = 13'd64;
    for (int n = 0; n <= 105; n++) cyc(1'b1, 1'b1, (n == 100) ? 500 : 0);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({oval, osop, corr_dtct} !== 3'b000 || odata_i !== '0 || odata_q !== '0) begin
      fails++; $display("FAIL t6_search_rst got flags=%b i=%h q=%h exp 0", {oval, osop, corr_dtct}, odata_i, odata_q);
    end
    release_reset;
    for (int n = 0; n <= 80; n++) begin
      cyc(1'b1, 1'b1, (n == 50) ? 500 : 0);
      tests++;
      if (corr_dtct !== (n >= 65) || osop !== (n == 66)) begin
        fails++; $display("FAIL t6_redetect n=%0d dtct=%b osop=%b", n, corr_dtct, osop);
      end
    end
    tests++;
    if (peak_val !== 24'd500) begin
      fails++; $display("FAIL t6_redetect_peak got %0d exp 500", peak_val);
    end

    apply_reset;
    for (int n = 0; n <= 115; n++) cyc(1'b1, 1'b1, (n == 100) ? 500 : 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 0);
      tests++;
      if (osop !== 1'b0 || corr_dtct !== 1'b1) begin
        fails++; $display("FAIL t6_pend_wait k=%0d osop=%b dtct=%b exp 0 1", k, osop, corr_dtct);
      end
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({oval, osop, corr_dtct} !== 3'b000 || peak_val !== '0) begin
      fails++; $display("FAIL t6_pend_rst got flags=%b pk=%0d exp 0", {oval, osop, corr_dtct}, peak_val);
    end
    release_reset;
    for (int n = 0; n < 30; n++) begin
      cyc(1'b1, 1'b1, 0);
      tests++;
      if (osop !== 1'b0 || corr_dtct !== 1'b0) begin
        fails++; $display("FAIL t6_no_sop n=%0d osop=%b dtct=%b exp 0 0", n, osop, corr_dtct);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ival = 1'b0; mval = 1'b0; metric = '0; data_i = '0; data_q = '0;
    thr_lvl = '0; addr_shft = '0; hold_len = '0;
    #2 rst = 1'b0;
    test_reset;
    test_no_detect_delay;
    test_single_peak;
    test_multi_peak;
    test_lockout;
    test_gapped;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
